// File: rtl/dds_pkg.sv
// Shared definitions for the tone DDS engine: waveform mode encoding and
// the legality check applied to every parameter set at elaboration.
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_ROM = 2'd0,
    MODE_SAW = 2'd1,
    MODE_SQR = 2'd2,
    MODE_TRI = 2'd3
  } mode_e;

  // A tick period shorter than the pipeline would put two samples in flight.
  function automatic bit params_ok(input int tick_div, input int step_w,
                                   input int step_mult, input int acc_w,
                                   input int adr_w, input int data_w,
                                   input int rom_lat);
    return (tick_div >= rom_lat + 4) &&
           (step_mult >= 1) && (step_mult <= 15) &&
           (acc_w >= step_w + 4) &&
           (rom_lat >= 1) && (rom_lat <= 3) &&
           (adr_w <= acc_w) && (data_w + 1 <= acc_w);
  endfunction

endpackage

// File: rtl/tone_dds_if.sv
// Control, ROM and sample-output bundle of the tone DDS engine.
// The slave side is the DDS itself; the master side is the surrounding chain.
interface tone_dds_if
  import dds_pkg::*;
#(
  parameter int STEP_W = 10,
  parameter int ADR_W  = 10,
  parameter int DATA_W = 10
);
  logic              enable;
  mode_e             mode;
  logic [STEP_W-1:0] step_in;
  logic              step_valid;
  logic              tick_out;
  logic [ADR_W-1:0]  rom_adr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] sample_out;
  logic              sample_load;

  modport master (
    output enable, mode, step_in, step_valid, rom_data,
    input  tick_out, rom_adr, sample_out, sample_load
  );

  modport slave (
    input  enable, mode, step_in, step_valid, rom_data,
    output tick_out, rom_adr, sample_out, sample_load
  );
endinterface

// File: rtl/sample_tick_gen.sv
// Modulo-TICK_DIV counter; o_tick is high for the single cycle in which
// the count sits at its terminal value.
module sample_tick_gen #(
  parameter int TICK_DIV = 5000
) (
  input  logic sysclk,
  input  logic rst_n,
  output logic o_tick
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = w_last;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (w_last) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/tone_dds.sv
// DDS tone engine: sample tick, step-scaled phase accumulator and a fixed
// latency waveform pipeline shared by the ROM and the synthetic waveforms.
module tone_dds
  import dds_pkg::*;
#(
  parameter int TICK_DIV  = 5000,
  parameter int STEP_W    = 10,
  parameter int STEP_MULT = 10,
  parameter int ACC_W     = 20,
  parameter int ADR_W     = 10,
  parameter int DATA_W    = 10,
  parameter int ROM_LAT   = 1
) (
  input  logic       sysclk,
  input  logic       rst_n,
  tone_dds_if.slave  bus
);
  if (!params_ok(TICK_DIV, STEP_W, STEP_MULT, ACC_W, ADR_W, DATA_W, ROM_LAT))
  begin : g_param_err
    $error("tone_dds: illegal parameter combination");
  end

  localparam int PROD_W = STEP_W + 4;
  localparam int VLD_D  = ROM_LAT + 3;

  typedef struct packed {
    mode_e             mode;
    logic [DATA_W-1:0] wave;
  } dl_t;

  function automatic logic [DATA_W-1:0] wave_of(input mode_e m,
                                                input logic [ACC_W-1:0] acc);
    case (m)
      MODE_SAW: return acc[ACC_W-1 -: DATA_W];
      MODE_SQR: return {DATA_W{acc[ACC_W-1]}};
      MODE_TRI: return acc[ACC_W-1] ? ~acc[ACC_W-2 -: DATA_W]
                                    :  acc[ACC_W-2 -: DATA_W];
      default:  return '0;
    endcase
  endfunction

  logic              w_tick;
  logic              w_adv;
  logic [PROD_W-1:0] w_inc;
  logic [STEP_W-1:0] r_step;
  logic [ACC_W-1:0]  r_acc;
  logic [VLD_D-1:0]  r_vld_p;
  mode_e             r_mode_p0;
  logic [ADR_W-1:0]  r_rom_adr_p1;
  dl_t               r_dl_p [0:ROM_LAT];
  logic [DATA_W-1:0] r_sample;

  sample_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .o_tick (w_tick)
  );

  assign w_adv = w_tick & bus.enable;
  assign w_inc = PROD_W'(r_step) * PROD_W'(STEP_MULT);

  assign bus.tick_out    = w_tick;
  assign bus.rom_adr     = r_rom_adr_p1;
  assign bus.sample_out  = r_sample;
  assign bus.sample_load = r_vld_p[VLD_D-1];

  // A step arriving with the tick lands after the accumulator has used the old one.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_step    <= '0;
      r_acc     <= '0;
      r_mode_p0 <= MODE_ROM;
      r_vld_p   <= '0;
    end else begin
      if (bus.step_valid) r_step <= bus.step_in;
      if (w_adv) begin
        r_acc     <= r_acc + ACC_W'(w_inc);
        r_mode_p0 <= bus.mode;
      end
      r_vld_p <= {r_vld_p[VLD_D-2:0], w_adv};
    end
  end

  // Stage p1: ROM address and synthetic waveform both taken from the new phase.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_adr_p1 <= '0;
      for (int k = 0; k <= ROM_LAT; k++) r_dl_p[k] <= '0;
    end else begin
      if (r_vld_p[0]) begin
        r_rom_adr_p1 <= r_acc[ACC_W-1 -: ADR_W];
        r_dl_p[0]    <= '{mode: r_mode_p0, wave: wave_of(r_mode_p0, r_acc)};
      end
      for (int k = 1; k <= ROM_LAT; k++) r_dl_p[k] <= r_dl_p[k-1];
    end
  end

  // Output stage: ROM data and delayed waveform arrive in the same cycle.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample <= '0;
    end else if (r_vld_p[ROM_LAT+1]) begin
      r_sample <= (r_dl_p[ROM_LAT].mode == MODE_ROM) ? bus.rom_data
                                                     : r_dl_p[ROM_LAT].wave;
    end
  end
endmodule
